// File: rtl/fxp_div_seq.sv
// fxp_div_seq: iterative signed fixed-point divider, q = (a << fracWidth) / b with saturation and divide-by-zero flag
module fxp_div_seq #(
  parameter int dataWidth = 16,
  parameter int fracWidth = 14
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  input  logic                 start,
  input  logic [dataWidth-1:0] a,
  input  logic [dataWidth-1:0] b,
  output logic                 busy,
  output logic                 done,
  output logic [dataWidth-1:0] q,
  output logic                 ovf,
  output logic                 dz
);
  localparam int n = dataWidth + fracWidth;
  localparam int cw = $clog2(n);
  localparam logic [1:0] idle = 2'd0, prep = 2'd1, div = 2'd2, fix = 2'd3;
  localparam logic [n-1:0] lim = {{fracWidth{1'b0}}, 1'b1, {(dataWidth-1){1'b0}}};
  localparam logic [dataWidth-1:0] maxpos = {1'b0, {(dataWidth-1){1'b1}}};
  localparam logic [dataWidth-1:0] minneg = {1'b1, {(dataWidth-1){1'b0}}};
  logic [1:0] state;
  logic [dataWidth-1:0] ra, rb, rem, amag, bmag, rn, qn;
  logic [n-1:0] dvd;
  logic [cw-1:0] cnt;
  logic [dataWidth:0] t;
  logic ge, sign, bz, ov, sat, neg;
  // most negative operand negates to 2^(dataWidth-1), still exact as an unsigned magnitude
  assign amag = ra[dataWidth-1] ? -ra : ra;
  assign bmag = rb[dataWidth-1] ? -rb : rb;
  assign sign = ra[dataWidth-1] ^ rb[dataWidth-1];
  assign bz = rb == '0;
  assign t = {rem, dvd[n-1]};
  assign ge = t >= {1'b0, bmag};
  assign rn = ge ? dataWidth'(t - {1'b0, bmag}) : t[dataWidth-1:0];
  assign ov = !bz && (sign ? dvd > lim : dvd >= lim);
  assign sat = bz || ov;
  assign neg = bz ? ra[dataWidth-1] : sign;
  assign qn = sat ? (neg ? minneg : maxpos) : (sign ? -dvd[dataWidth-1:0] : dvd[dataWidth-1:0]);
  assign busy = state != idle;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= idle;
      ra <= '0;
      rb <= '0;
      rem <= '0;
      dvd <= '0;
      cnt <= '0;
      done <= 1'b0;
      q <= '0;
      ovf <= 1'b0;
      dz <= 1'b0;
    end else if (ce) begin
      done <= state == fix;
      case (state)
        idle: if (start) begin
          ra <= a;
          rb <= b;
          state <= prep;
        end
        prep: begin
          dvd <= {amag, {fracWidth{1'b0}}};
          rem <= '0;
          cnt <= cw'(n - 1);
          state <= div;
        end
        div: begin
          dvd <= {dvd[n-2:0], ge};
          rem <= rn;
          cnt <= cnt - 1'b1;
          state <= cnt == '0 ? fix : div;
        end
        default: begin
          q <= qn;
          ovf <= ov;
          dz <= bz;
          state <= idle;
        end
      endcase
    end
  end
endmodule
